// File: rtl/store_align_buffer.sv
// store_align_buffer: store queue plus byte-lane aligner for the data-memory write port.
// Each queued store becomes one aligned bus beat with a byte mask. A store that crosses
// a bus word becomes two beats (LO then HI).
// Optional feature macro: MISALIGNED_SPLIT_EN. When it is defined, misaligned stores are
// queued and split as needed. When it is undefined, misaligned stores fault and the HI
// state does not exist.
// The XLEN parameter defaults to 64 and is overridden per instance.
module store_align_buffer #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              StValid_M,
  output logic              StReady_M,
  input  logic [XLEN-1:0]   StAddr_M,
  input  logic [XLEN-1:0]   StData_M,
  input  logic [1:0]        StSize_M,
  output logic              StFault_M,
  output logic              MemWrValid,
  input  logic              MemWrReady,
  output logic [XLEN-1:0]   MemWrAddr,
  output logic [XLEN-1:0]   MemWrData,
  output logic [XLEN/8-1:0] MemWrMask,
  output logic              Empty
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1
`ifdef MISALIGNED_SPLIT_EN
    , S_HI = 2'd2
`endif
  } state_t;

  logic [XLEN-1:0] q_addr [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [1:0]      q_size [DEPTH];
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [CNTW-1:0] count;
  state_t          state;

  logic            push, pop, full, avail_q, load_lo;
  logic [PTRW-1:0] next_idx;
  logic [XLEN-1:0] src_addr, src_data;
  logic [1:0]      src_size;
  logic [OFFW-1:0] src_off;
  logic [XLEN-1:0] lo_addr, lo_data;
  logic [NB-1:0]   lo_mask;

  // Byte-enable pattern of an access size, right-justified.
  function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(8'h01);
      2'd1:    m = NB'(8'h03);
      2'd2:    m = NB'(8'h0F);
      default: m = NB'(8'hFF);
    endcase
    return m;
  endfunction

`ifndef MISALIGNED_SPLIT_EN
  // True when the address is not a multiple of the access size.
  function automatic logic misaligned(input logic [2:0] a, input logic [1:0] size);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = a[0];
      2'd2:    r = |a[1:0];
      default: r = |a[2:0];
    endcase
    return r;
  endfunction
`endif

`ifdef MISALIGNED_SPLIT_EN
  logic            cross_head;
  logic [OFFW-1:0] head_off;
  logic [XLEN-1:0] hi_data;
  logic [NB-1:0]   hi_mask;

  // The HI beat carries the bytes that spill past the end of the bus word.
  always_comb begin
    head_off   = q_addr[rd_ptr][OFFW-1:0];
    hi_mask    = size_mask(q_size[rd_ptr]) >> (NB - int'(head_off));
    hi_data    = q_data[rd_ptr] >> (XLEN - 8 * int'(head_off));
    cross_head = |hi_mask;
  end
`endif

  // Fault detection, queue handshake and selection of the next LO beat's source.
  always_comb begin
`ifdef MISALIGNED_SPLIT_EN
    StFault_M = StValid_M & ((XLEN == 32) && (StSize_M == 2'b11));
    pop = MemWrValid & MemWrReady & ((state == S_HI) | ((state == S_LO) & !cross_head));
`else
    StFault_M = StValid_M & (((XLEN == 32) && (StSize_M == 2'b11)) |
                             misaligned(StAddr_M[2:0], StSize_M));
    pop = MemWrValid & MemWrReady;
`endif
    full      = (count == CNTW'(DEPTH));
    StReady_M = !full | pop;
    push      = StValid_M & StReady_M & !StFault_M;
    next_idx  = rd_ptr + PTRW'(pop);
    avail_q   = (count != CNTW'(pop));
    load_lo   = ((state == S_IDLE) | pop) & (avail_q | push);
    if (avail_q) begin
      src_addr = q_addr[next_idx];
      src_data = q_data[next_idx];
      src_size = q_size[next_idx];
    end else begin
      src_addr = StAddr_M;
      src_data = StData_M;
      src_size = StSize_M;
    end
    src_off = src_addr[OFFW-1:0];
    lo_addr = {src_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    lo_data = src_data << {src_off, 3'b000};
    lo_mask = size_mask(src_size) << src_off;
    Empty   = (count == '0) & (state == S_IDLE);
  end

  // Store queue: circular buffer with push at the tail and pop after the entry's last beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_size[i] <= 2'b00;
      end
    end else begin
      if (push) begin
        q_addr[wr_ptr] <= StAddr_M;
        q_data[wr_ptr] <= StData_M;
        q_size[wr_ptr] <= StSize_M;
        wr_ptr         <= wr_ptr + PTRW'(1'b1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1'b1);
      end
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  // Beat FSM: drives the registered write port and holds it until MemWrReady.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      MemWrValid <= 1'b0;
      MemWrAddr  <= '0;
      MemWrData  <= '0;
      MemWrMask  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_lo) begin
            state      <= S_LO;
            MemWrValid <= 1'b1;
            MemWrAddr  <= lo_addr;
            MemWrData  <= lo_data;
            MemWrMask  <= lo_mask;
          end
        end
`ifdef MISALIGNED_SPLIT_EN
        S_LO, S_HI: begin
          if (MemWrReady && (state == S_LO) && cross_head) begin
            state     <= S_HI;
            MemWrAddr <= MemWrAddr + XLEN'(NB);
            MemWrData <= hi_data;
            MemWrMask <= hi_mask;
          end else if (MemWrReady) begin
`else
        S_LO: begin
          if (MemWrReady) begin
`endif
            if (load_lo) begin
              state      <= S_LO;
              MemWrValid <= 1'b1;
              MemWrAddr  <= lo_addr;
              MemWrData  <= lo_data;
              MemWrMask  <= lo_mask;
            end else begin
              state      <= S_IDLE;
              MemWrValid <= 1'b0;
              MemWrAddr  <= '0;
              MemWrData  <= '0;
              MemWrMask  <= '0;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          MemWrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_buffer.sv
// Directed bench for store_align_buffer (XLEN=64, DEPTH=2) plus an XLEN=32 instance
// for the illegal-size fault.
module tb_store_align_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        st_valid, st_ready, st_fault, wr_valid, wr_ready, empty;
  logic [63:0] st_addr, st_data, wr_addr, wr_data;
  logic [1:0]  st_size;
  logic [7:0]  wr_mask;

  logic        st_valid32, st_ready32, st_fault32, wr_valid32, empty32;
  logic [31:0] st_addr32, st_data32, wr_addr32, wr_data32;
  logic [1:0]  st_size32;
  logic [3:0]  wr_mask32;

  store_align_buffer #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .StValid_M(st_valid), .StReady_M(st_ready), .StAddr_M(st_addr), .StData_M(st_data),
    .StSize_M(st_size), .StFault_M(st_fault),
    .MemWrValid(wr_valid), .MemWrReady(wr_ready), .MemWrAddr(wr_addr),
    .MemWrData(wr_data), .MemWrMask(wr_mask), .Empty(empty)
  );

  store_align_buffer #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .reset_n(reset_n),
    .StValid_M(st_valid32), .StReady_M(st_ready32), .StAddr_M(st_addr32),
    .StData_M(st_data32), .StSize_M(st_size32), .StFault_M(st_fault32),
    .MemWrValid(wr_valid32), .MemWrReady(1'b1), .MemWrAddr(wr_addr32),
    .MemWrData(wr_data32), .MemWrMask(wr_mask32), .Empty(empty32)
  );

  typedef struct {
    string       name;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
    logic        fault;
    logic [63:0] eaddr;
    logic [63:0] edata;
    logic [7:0]  emask;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = s;
  endtask

  task automatic check_beat(input string name, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] m);
    check({name, " valid"}, {63'd0, wr_valid}, 64'd1);
    check({name, " addr"}, wr_addr, a);
    check({name, " data"}, wr_data, d);
    check({name, " mask"}, {56'd0, wr_mask}, {56'd0, m});
  endtask

  initial begin
    reset_n = 1'b0; wr_ready = 1'b1;
    st_valid = 1'b0; st_addr = 64'd0; st_data = 64'd0; st_size = 2'b00;
    st_valid32 = 1'b0; st_addr32 = 32'd0; st_data32 = 32'd0; st_size32 = 2'b00;

    vecs.push_back('{"sw_104", 64'h104, 64'hDEADBEEF, 2'd2, 1'b0, 64'h100, 64'hDEADBEEF_00000000, 8'hF0});
    vecs.push_back('{"sb_7", 64'h7, 64'hAB, 2'd0, 1'b0, 64'h0, 64'hAB00_0000_0000_0000, 8'h80});
    vecs.push_back('{"sh_2", 64'h2, 64'hCAFE, 2'd1, 1'b0, 64'h0, 64'h0000_0000_CAFE_0000, 8'h0C});
    vecs.push_back('{"sd_208", 64'h208, 64'h0123456789ABCDEF, 2'd3, 1'b0, 64'h208, 64'h0123456789ABCDEF, 8'hFF});
    vecs.push_back('{"sb_10", 64'h10, 64'h5A, 2'd0, 1'b0, 64'h10, 64'h5A, 8'h01});
    vecs.push_back('{"sw_100", 64'h100, 64'h11223344, 2'd2, 1'b0, 64'h100, 64'h11223344, 8'h0F});
`ifdef MISALIGNED_SPLIT_EN
    vecs.push_back('{"sh_3", 64'h3, 64'h1234, 2'd1, 1'b0, 64'h0, 64'h0000_0012_3400_0000, 8'h18});
`else
    vecs.push_back('{"sh_3", 64'h3, 64'h1234, 2'd1, 1'b1, 64'h0, 64'h0, 8'h00});
    vecs.push_back('{"sw_106", 64'h106, 64'h11223344, 2'd2, 1'b1, 64'h0, 64'h0, 8'h00});
    vecs.push_back('{"sd_20c", 64'h20C, 64'h55, 2'd3, 1'b1, 64'h0, 64'h0, 8'h00});
`endif

    // Reset state
    #7;
    check("rst valid", {63'd0, wr_valid}, 64'd0);
    check("rst empty", {63'd0, empty}, 64'd1);
    check("rst addr", wr_addr, 64'd0);
    check("rst mask", {56'd0, wr_mask}, 64'd0);
    check("rst ready", {63'd0, st_ready}, 64'd1);
    @(negedge clk); reset_n = 1'b1;

    // Table: single-beat stores and faults, memory always ready
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].addr, vecs[i].data, vecs[i].size);
      #1 check({vecs[i].name, " fault"}, {63'd0, st_fault}, {63'd0, vecs[i].fault});
      @(negedge clk);
      st_valid = 1'b0;
      if (vecs[i].fault) begin
        check({vecs[i].name, " no beat"}, {63'd0, wr_valid}, 64'd0);
        check({vecs[i].name, " still empty"}, {63'd0, empty}, 64'd1);
      end else begin
        check_beat(vecs[i].name, vecs[i].eaddr, vecs[i].edata, vecs[i].emask);
      end
      @(negedge clk);
      check({vecs[i].name, " drained"}, {63'd0, empty}, 64'd1);
    end

`ifdef MISALIGNED_SPLIT_EN
    // Crossing store: two consecutive beats
    @(negedge clk);
    drive(64'h106, 64'h11223344, 2'd2);
    #1 check("split fault", {63'd0, st_fault}, 64'd0);
    @(negedge clk); st_valid = 1'b0;
    check_beat("split lo", 64'h100, 64'h3344_0000_0000_0000, 8'hC0);
    @(negedge clk);
    check_beat("split hi", 64'h108, 64'h1122, 8'h03);
    @(negedge clk);
    check("split drained", {63'd0, empty}, 64'd1);
`endif

    // Backpressure: DEPTH=2 fills, third request stalls, then in-order drain
    wr_ready = 1'b0;
    @(negedge clk);
    drive(64'h104, 64'hDEADBEEF, 2'd2);
    @(negedge clk);
    drive(64'h7, 64'hAB, 2'd0);
    #1 check("bp ready 2nd", {63'd0, st_ready}, 64'd1);
    @(negedge clk);
    drive(64'h208, 64'h0123456789ABCDEF, 2'd3);
    #1 check("bp ready 3rd", {63'd0, st_ready}, 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_beat("bp hold", 64'h100, 64'hDEADBEEF_00000000, 8'hF0);
    end
    wr_ready = 1'b1;
    #1 check("bp ready on pop", {63'd0, st_ready}, 64'd1);
    @(negedge clk); st_valid = 1'b0;
    check_beat("bp 2nd", 64'h0, 64'hAB00_0000_0000_0000, 8'h80);
    @(negedge clk);
    check_beat("bp 3rd", 64'h208, 64'h0123456789ABCDEF, 8'hFF);
    @(negedge clk);
    check("bp valid off", {63'd0, wr_valid}, 64'd0);
    check("bp empty", {63'd0, empty}, 64'd1);

    // Reset asserted while a beat is held
    wr_ready = 1'b0;
    @(negedge clk);
    drive(64'h10, 64'h5A, 2'd0);
    @(negedge clk); st_valid = 1'b0;
    check("mid valid before", {63'd0, wr_valid}, 64'd1);
    check("mid empty before", {63'd0, empty}, 64'd0);
    #2 reset_n = 1'b0;
    #1 check("mid rst valid", {63'd0, wr_valid}, 64'd0);
    check("mid rst empty", {63'd0, empty}, 64'd1);
    check("mid rst addr", wr_addr, 64'd0);
    @(negedge clk); reset_n = 1'b1; wr_ready = 1'b1;
    @(negedge clk);
    check("post rst valid", {63'd0, wr_valid}, 64'd0);
    check("post rst empty", {63'd0, empty}, 64'd1);

    // XLEN=32: double-word store is illegal, word store is not
    @(negedge clk);
    st_valid32 = 1'b1; st_addr32 = 32'h0; st_size32 = 2'd3;
    #1 check("x32 sd fault", {63'd0, st_fault32}, 64'd1);
    st_size32 = 2'd2; st_addr32 = 32'h4;
    #1 check("x32 sw fault", {63'd0, st_fault32}, 64'd0);
    st_valid32 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
